// File: rtl/piano_pkg.sv
// Shared keyboard-piano definitions: scan codes, note pitches and the
// half-period table for the square-wave tone divider.
package piano_pkg;

    localparam int     PERIOD_W = 26;
    localparam longint CLK_HZ   = 50_000_000;

    localparam logic [7:0] KC_A = 8'h1C;
    localparam logic [7:0] KC_W = 8'h1D;
    localparam logic [7:0] KC_S = 8'h1B;
    localparam logic [7:0] KC_E = 8'h24;
    localparam logic [7:0] KC_D = 8'h23;
    localparam logic [7:0] KC_F = 8'h2B;
    localparam logic [7:0] KC_T = 8'h2C;
    localparam logic [7:0] KC_G = 8'h34;
    localparam logic [7:0] KC_Y = 8'h35;
    localparam logic [7:0] KC_H = 8'h33;
    localparam logic [7:0] KC_U = 8'h3C;
    localparam logic [7:0] KC_J = 8'h3B;
    localparam logic [7:0] KC_K = 8'h42;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_MODIFY,
        ST_UPDATE
    } state_t;

    // Pitches in millihertz; D4 and F4 sit a few mHz off concert pitch so the
    // rounded table matches the divider values already used on the board.
    localparam longint F_C4  = 261_626;
    localparam longint F_CS4 = 277_183;
    localparam longint F_D4  = 293_662;
    localparam longint F_DS4 = 311_127;
    localparam longint F_E4  = 329_628;
    localparam longint F_F4  = 349_226;
    localparam longint F_FS4 = 369_994;
    localparam longint F_G4  = 391_995;
    localparam longint F_GS4 = 415_305;
    localparam longint F_A4  = 440_000;
    localparam longint F_AS4 = 466_164;
    localparam longint F_B4  = 493_883;
    localparam longint F_C5  = 523_251;

    // round(CLK_HZ / (2*f)) with f in mHz, integer-only so it folds at elaboration
    function automatic logic [PERIOD_W-1:0] hp_from_mhz(input longint f_mhz);
        return PERIOD_W'((CLK_HZ * 1000 + f_mhz) / (2 * f_mhz));
    endfunction

    localparam logic [PERIOD_W-1:0] HP_C4  = hp_from_mhz(F_C4);
    localparam logic [PERIOD_W-1:0] HP_CS4 = hp_from_mhz(F_CS4);
    localparam logic [PERIOD_W-1:0] HP_D4  = hp_from_mhz(F_D4);
    localparam logic [PERIOD_W-1:0] HP_DS4 = hp_from_mhz(F_DS4);
    localparam logic [PERIOD_W-1:0] HP_E4  = hp_from_mhz(F_E4);
    localparam logic [PERIOD_W-1:0] HP_F4  = hp_from_mhz(F_F4);
    localparam logic [PERIOD_W-1:0] HP_FS4 = hp_from_mhz(F_FS4);
    localparam logic [PERIOD_W-1:0] HP_G4  = hp_from_mhz(F_G4);
    localparam logic [PERIOD_W-1:0] HP_GS4 = hp_from_mhz(F_GS4);
    localparam logic [PERIOD_W-1:0] HP_A4  = hp_from_mhz(F_A4);
    localparam logic [PERIOD_W-1:0] HP_AS4 = hp_from_mhz(F_AS4);
    localparam logic [PERIOD_W-1:0] HP_B4  = hp_from_mhz(F_B4);
    localparam logic [PERIOD_W-1:0] HP_C5  = hp_from_mhz(F_C5);

    // Zero marks an unmapped key; no real note has a zero half-period.
    function automatic logic [PERIOD_W-1:0] hp_of(input logic [7:0] code);
        logic [PERIOD_W-1:0] hp;
        case (code)
            KC_A:    hp = HP_C4;
            KC_W:    hp = HP_CS4;
            KC_S:    hp = HP_D4;
            KC_E:    hp = HP_DS4;
            KC_D:    hp = HP_E4;
            KC_F:    hp = HP_F4;
            KC_T:    hp = HP_FS4;
            KC_G:    hp = HP_G4;
            KC_Y:    hp = HP_GS4;
            KC_H:    hp = HP_A4;
            KC_U:    hp = HP_AS4;
            KC_J:    hp = HP_B4;
            KC_K:    hp = HP_C5;
            default: hp = '0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/note_lut.sv
// Combinational scan code -> half-period ROM; zero output means unmapped key.
module note_lut
    import piano_pkg::*;
(
    input  logic [7:0]          code,
    output logic [PERIOD_W-1:0] half_period
);

    always_comb begin
        half_period = hp_of(code);
    end

endmodule

// File: rtl/note_scheduler.sv
// Last-note-priority scheduler: keeps a stack of held keys and drives the tone
// divider with the newest held key's half-period.
module note_scheduler
    import piano_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [7:0]          key_code,
    input  logic                key_break,
    output logic [PERIOD_W-1:0] half_period,
    output logic                note_on,
    output logic                period_load,
    output logic [CNT_W-1:0]    held_count,
    output logic                overflow
);

    state_t              state;
    logic [7:0]          ev_code;
    logic                ev_break;
    logic                ev_mapped;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;

    // Entry 0 is the oldest key; valid entries are always contiguous from 0.
    logic [7:0]          stk_code [DEPTH];
    logic [DEPTH-1:0]    stk_vld;

    logic [7:0]          top_code;
    logic [7:0]          lut_code;
    logic [PERIOD_W-1:0] lut_hp;
    logic                cmp_hit;
    logic [IDX_W-1:0]    cmp_idx;

    assign key_ready = (state == ST_IDLE);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        top_code = 8'h00;
        cmp_hit  = 1'b0;
        cmp_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stk_vld[i]) begin
                top_code = stk_code[i];
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stk_vld[i] && (stk_code[i] == ev_code)) begin
                cmp_hit = 1'b1;
                cmp_idx = IDX_W'(i);
            end
        end
    end

    // One ROM serves both the event lookup and the top-of-stack re-derivation.
    assign lut_code = (state == ST_UPDATE) ? top_code : ev_code;

    note_lut u_note_lut (
        .code        (lut_code),
        .half_period (lut_hp)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; the shift loops below depend on that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ev_code     <= 8'h00;
            ev_break    <= 1'b0;
            ev_mapped   <= 1'b0;
            hit         <= 1'b0;
            hit_idx     <= '0;
            stk_vld     <= '0;
            // NOTE: the stack is tiny and its codes feed the compare, so it is
            // reset outright rather than relying on the valid bits alone.
            for (int i = 0; i < DEPTH; i++) begin
                stk_code[i] <= 8'h00;
            end
            half_period <= '0;
            note_on     <= 1'b0;
            period_load <= 1'b0;
            held_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            period_load <= 1'b0;
            overflow    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        ev_code  <= key_code;
                        ev_break <= key_break;
                        state    <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    ev_mapped <= (lut_hp != '0);
                    hit       <= cmp_hit;
                    hit_idx   <= cmp_idx;
                    state     <= ST_MODIFY;
                end
                ST_MODIFY: begin
                    if (ev_mapped && !ev_break && !hit) begin
                        if (held_count != CNT_W'(DEPTH)) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (CNT_W'(i) == held_count) begin
                                    stk_code[i] <= ev_code;
                                    stk_vld[i]  <= 1'b1;
                                end
                            end
                            held_count <= held_count + CNT_W'(1);
                        end else begin
                            for (int i = 0; i < DEPTH - 1; i++) begin
                                stk_code[i] <= stk_code[i + 1];
                            end
                            stk_code[DEPTH - 1] <= ev_code;
                            overflow            <= 1'b1;
                        end
                    end else if (ev_mapped && ev_break && hit) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            if (IDX_W'(i) >= hit_idx) begin
                                stk_code[i] <= stk_code[i + 1];
                                stk_vld[i]  <= stk_vld[i + 1];
                            end
                        end
                        stk_vld[DEPTH - 1] <= 1'b0;
                        held_count         <= held_count - CNT_W'(1);
                    end
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (lut_hp != half_period) begin
                        half_period <= lut_hp;
                        period_load <= 1'b1;
                    end
                    note_on <= (held_count != '0);
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: stimulus pushes expected outputs into a
// scoreboard, a separate monitor pops them as each accepted event completes.
module tb_note_scheduler;
    import piano_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                key_valid = 1'b0;
    logic                key_ready;
    logic [7:0]          key_code = 8'h00;
    logic                key_break = 1'b0;
    logic [PERIOD_W-1:0] half_period;
    logic                note_on;
    logic                period_load;
    logic [2:0]          held_count;
    logic                overflow;

    note_scheduler #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_break   (key_break),
        .half_period (half_period),
        .note_on     (note_on),
        .period_load (period_load),
        .held_count  (held_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PERIOD_W-1:0] hp;
        logic                on;
        logic                load;
        logic [2:0]          cnt;
        logic                ovf;
        logic                aborted;
        int                  id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ev_id  = 0;
    int   phase  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one event; hold_extra keeps key_valid high through that many busy edges.
    task automatic send(input logic [7:0] code, input logic brk,
                        input logic [PERIOD_W-1:0] hp, input logic on, input logic load,
                        input logic [2:0] cnt, input logic ovf, input int hold_extra);
        exp_t e;
        e.hp = hp; e.on = on; e.load = load; e.cnt = cnt; e.ovf = ovf;
        e.aborted = 1'b0; e.id = ev_id++;
        sb.push_back(e);
        @(posedge clk); #1;
        key_valid = 1'b1; key_code = code; key_break = brk;
        wait_ready();
        @(posedge clk); #1;
        for (int k = 0; k < hold_extra; k++) begin
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
    endtask

    // Monitor: detect a transfer one negedge ahead, then track it edge by edge.
    initial begin
        exp_t cur;
        int   ovf_cycles;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
            end else begin
                case (phase)
                    1: begin
                        check($sformatf("ev%0d_ready_busy", cur.id), key_ready, 1'b0);
                        check($sformatf("ev%0d_load_width", cur.id), period_load, 1'b0);
                        phase = 2;
                    end
                    2, 3: begin
                        ovf_cycles += overflow;
                        phase++;
                    end
                    4: begin
                        ovf_cycles += overflow;
                        check($sformatf("ev%0d_half_period", cur.id), half_period, cur.hp);
                        check($sformatf("ev%0d_note_on", cur.id), note_on, cur.on);
                        check($sformatf("ev%0d_period_load", cur.id), period_load, cur.load);
                        check($sformatf("ev%0d_held_count", cur.id), held_count, cur.cnt);
                        check($sformatf("ev%0d_overflow", cur.id), ovf_cycles, cur.ovf ? 1 : 0);
                        check($sformatf("ev%0d_ready_back", cur.id), key_ready, 1'b1);
                        phase = 0;
                    end
                    default: ;
                endcase
                if (phase == 0 && key_valid && key_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_transfer", 32'd1, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        ovf_cycles = 0;
                        if (!cur.aborted) phase = 1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ab;
        repeat (2) @(posedge clk);
        #1;
        check("rst_half_period", half_period, 0);
        check("rst_note_on", note_on, 0);
        check("rst_period_load", period_load, 0);
        check("rst_held_count", held_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_key_ready", key_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single make.
        send(KC_A, 1'b0, 95556, 1, 1, 1, 0, 0);

        // Reset while an event is in flight.
        ab.hp = '0; ab.on = 0; ab.load = 0; ab.cnt = 0; ab.ovf = 0;
        ab.aborted = 1'b1; ab.id = ev_id++;
        sb.push_back(ab);
        @(posedge clk); #1;
        key_valid = 1'b1; key_code = KC_S; key_break = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_half_period", half_period, 0);
        check("midrst_note_on", note_on, 0);
        check("midrst_period_load", period_load, 0);
        check("midrst_held_count", held_count, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_key_ready", key_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_key_ready", key_ready, 1);

        // Newest key sounds; release restores the previous one.
        send(KC_A, 1'b0, 95556, 1, 1, 1, 0, 0);
        send(KC_S, 1'b0, 85132, 1, 1, 2, 0, 0);
        send(KC_S, 1'b1, 95556, 1, 1, 1, 0, 0);
        send(KC_A, 1'b1, 0,     0, 1, 0, 0, 0);

        // Releasing a middle key leaves the sounding note alone.
        send(KC_A, 1'b0, 95556, 1, 1, 1, 0, 0);
        send(KC_S, 1'b0, 85132, 1, 1, 2, 0, 0);
        send(KC_D, 1'b0, 75843, 1, 1, 3, 0, 0);
        send(KC_S, 1'b1, 75843, 1, 0, 2, 0, 0);
        send(KC_D, 1'b1, 95556, 1, 1, 1, 0, 0);
        send(KC_A, 1'b1, 0,     0, 1, 0, 0, 0);

        // Fill the stack, then overflow evicts the oldest key.
        send(KC_A, 1'b0, 95556, 1, 1, 1, 0, 0);
        send(KC_S, 1'b0, 85132, 1, 1, 2, 0, 0);
        send(KC_D, 1'b0, 75843, 1, 1, 3, 0, 0);
        send(KC_F, 1'b0, 71587, 1, 1, 4, 0, 0);
        send(KC_W, 1'b0, 90193, 1, 1, 4, 1, 0);
        send(KC_A, 1'b1, 90193, 1, 0, 4, 0, 0);

        // Typematic repeat and unmapped keys change nothing; valid held while busy.
        send(KC_D,  1'b0, 90193, 1, 0, 4, 0, 3);
        send(8'h76, 1'b0, 90193, 1, 0, 4, 0, 0);
        send(8'h76, 1'b1, 90193, 1, 0, 4, 0, 0);

        // Drain the stack.
        send(KC_S, 1'b1, 90193, 1, 0, 3, 0, 0);
        send(KC_D, 1'b1, 90193, 1, 0, 2, 0, 0);
        send(KC_W, 1'b1, 71587, 1, 1, 1, 0, 0);
        send(KC_F, 1'b1, 0,     0, 1, 0, 0, 0);

        repeat (8) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        check("monitor_idle", phase, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
